// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for the register file: read ports, two write ports, issue port
// and the scoreboard/stall outputs. The control unit holds the master side,
// the register file the slave side.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    localparam int NREG = 1 << ADDR_W;

    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;

    logic              we_a;
    logic [ADDR_W-1:0] wa_a;
    logic [DATA_W-1:0] wd_a;
    logic              we_b;
    logic [ADDR_W-1:0] wa_b;
    logic [DATA_W-1:0] wd_b;

    logic              issue_en;
    logic [ADDR_W-1:0] issue_rd;

    logic              stall_rs;
    logic              stall_rt;
    logic [NREG-1:0]   pending;

    modport master (
        output rs, rt,
        output we_a, wa_a, wd_a,
        output we_b, wa_b, wd_b,
        output issue_en, issue_rd,
        input  rd_data1, rd_data2,
        input  stall_rs, stall_rt, pending
    );

    modport slave (
        input  rs, rt,
        input  we_a, wa_a, wd_a,
        input  we_b, wa_b, wd_b,
        input  issue_en, issue_rd,
        output rd_data1, rd_data2,
        output stall_rs, stall_rt, pending
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with two asynchronous read ports, two synchronous
// write ports (port B wins on collision), optional same-cycle forwarding,
// optional hardwired-zero register 0, and a per-register pending scoreboard
// used by the control unit to stall on read-after-write hazards.
module regfile_scoreboard #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 clr,
    regfile_scoreboard_if.slave  bus
);

    localparam int NREG     = 1 << ADDR_W;
    localparam bit HAS_ZERO = (ZERO_REG != 0);
    localparam bit HAS_BYP  = (BYPASS != 0);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pend;

    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rdata [2];
    logic              stall [2];

    assign raddr[0] = bus.rs;
    assign raddr[1] = bus.rt;

    // One storage entry and one scoreboard bit per register. A hardwired
    // zero register gets no storage at all, so it can never hold data or
    // go pending.
    for (genvar g = 0; g < NREG; g++) begin : g_entry
        if (HAS_ZERO && g == 0) begin : g_zero
            assign regs[g] = '0;
            assign pend[g] = 1'b0;
        end else begin : g_live
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(g);

            logic [DATA_W-1:0] q;
            logic              p;
            logic              hit_a;
            logic              hit_b;
            logic              set_p;

            assign hit_a = bus.we_a && (bus.wa_a == IDX);
            assign hit_b = bus.we_b && (bus.wa_b == IDX);
            assign set_p = bus.issue_en && (bus.issue_rd == IDX);

            // Register contents; port B has priority when both ports
            // target this entry in the same cycle.
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    q <= '0;
                end else if (hit_b) begin
                    q <= bus.wd_b;
                end else if (hit_a) begin
                    q <= bus.wd_a;
                end
            end

            // Scoreboard bit: a new issue outranks a writeback, since the
            // newly issued producer is still outstanding.
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    p <= 1'b0;
                end else if (set_p) begin
                    p <= 1'b1;
                end else if (hit_a || hit_b) begin
                    p <= 1'b0;
                end
            end

            assign regs[g] = q;
            assign pend[g] = p;
        end
    end

    // Read data and stall for both read ports: forward B, then A, then the
    // stored value; register 0 reads zero when hardwired. A writeback that
    // is being forwarded this cycle resolves the hazard, so it drops stall.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            logic wr_hit_a;
            logic wr_hit_b;
            wr_hit_a = bus.we_a && (bus.wa_a == raddr[p]);
            wr_hit_b = bus.we_b && (bus.wa_b == raddr[p]);

            rdata[p] = regs[raddr[p]];
            if (HAS_BYP) begin
                if (wr_hit_b) begin
                    rdata[p] = bus.wd_b;
                end else if (wr_hit_a) begin
                    rdata[p] = bus.wd_a;
                end
            end
            if (HAS_ZERO && raddr[p] == '0) begin
                rdata[p] = '0;
            end

            stall[p] = pend[raddr[p]] && !(HAS_BYP && (wr_hit_a || wr_hit_b));
        end
    end

    assign bus.rd_data1 = rdata[0];
    assign bus.rd_data2 = rdata[1];
    assign bus.stall_rs = stall[0];
    assign bus.stall_rt = stall[1];
    assign bus.pending  = pend;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard. Two instances share one stimulus stream:
// instance 0 uses the defaults (forwarding on, no zero register), instance 1
// has forwarding off and a hardwired zero register. Each is compared to a
// behavioural model of the register file and scoreboard.
module tb_regfile_scoreboard;

    logic clk;
    logic clr;

    logic [1:0] rs, rt;
    logic       we_a, we_b, issue_en;
    logic [1:0] wa_a, wa_b, issue_rd;
    logic [7:0] wd_a, wd_b;

    int total;
    int bad;

    regfile_scoreboard_if #(.DATA_W(8), .ADDR_W(2)) if0 ();
    regfile_scoreboard_if #(.DATA_W(8), .ADDR_W(2)) if1 ();

    assign if0.rs = rs;             assign if1.rs = rs;
    assign if0.rt = rt;             assign if1.rt = rt;
    assign if0.we_a = we_a;         assign if1.we_a = we_a;
    assign if0.wa_a = wa_a;         assign if1.wa_a = wa_a;
    assign if0.wd_a = wd_a;         assign if1.wd_a = wd_a;
    assign if0.we_b = we_b;         assign if1.we_b = we_b;
    assign if0.wa_b = wa_b;         assign if1.wa_b = wa_b;
    assign if0.wd_b = wd_b;         assign if1.wd_b = wd_b;
    assign if0.issue_en = issue_en; assign if1.issue_en = issue_en;
    assign if0.issue_rd = issue_rd; assign if1.issue_rd = issue_rd;

    regfile_scoreboard #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) dut0 (
        .clk (clk),
        .clr (clr),
        .bus (if0)
    );

    regfile_scoreboard #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1), .BYPASS(0)) dut1 (
        .clk (clk),
        .clr (clr),
        .bus (if1)
    );

    logic [7:0] obs_rd1 [2];
    logic [7:0] obs_rd2 [2];
    logic       obs_srs [2];
    logic       obs_srt [2];
    logic [3:0] obs_pend [2];

    assign obs_rd1[0] = if0.rd_data1;  assign obs_rd1[1] = if1.rd_data1;
    assign obs_rd2[0] = if0.rd_data2;  assign obs_rd2[1] = if1.rd_data2;
    assign obs_srs[0] = if0.stall_rs;  assign obs_srs[1] = if1.stall_rs;
    assign obs_srt[0] = if0.stall_rt;  assign obs_srt[1] = if1.stall_rt;
    assign obs_pend[0] = if0.pending;  assign obs_pend[1] = if1.pending;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arrays of register values and pending flags.
    bit         zero_cfg [2] = '{1'b0, 1'b1};
    bit         byp_cfg  [2] = '{1'b1, 1'b0};
    logic [7:0] mreg  [2][4];
    bit         mpend [2][4];

    function automatic void modelReset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 4; i++) begin
                mreg[c][i]  = 8'h00;
                mpend[c][i] = 1'b0;
            end
        end
    endfunction

    function automatic bit writing(input logic [1:0] addr);
        return (we_a && wa_a == addr) || (we_b && wa_b == addr);
    endfunction

    function automatic logic [7:0] expRead(input int c, input logic [1:0] addr);
        if (zero_cfg[c] && addr == 2'd0) return 8'h00;
        if (byp_cfg[c]) begin
            if (we_b && wa_b == addr) return wd_b;
            if (we_a && wa_a == addr) return wd_a;
        end
        return mreg[c][addr];
    endfunction

    function automatic bit expStall(input int c, input logic [1:0] addr);
        return mpend[c][addr] && !(byp_cfg[c] && writing(addr));
    endfunction

    function automatic logic [3:0] expPending(input int c);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = mpend[c][i];
        return v;
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    function automatic void modelEdge();
        for (int c = 0; c < 2; c++) begin
            if (we_a && !(zero_cfg[c] && wa_a == 2'd0)) begin
                mreg[c][wa_a]  = wd_a;
                mpend[c][wa_a] = 1'b0;
            end
            if (we_b && !(zero_cfg[c] && wa_b == 2'd0)) begin
                mreg[c][wa_b]  = wd_b;
                mpend[c][wa_b] = 1'b0;
            end
            if (issue_en && !(zero_cfg[c] && issue_rd == 2'd0)) begin
                mpend[c][issue_rd] = 1'b1;
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string step, input bit with_data);
        for (int c = 0; c < 2; c++) begin
            if (with_data) begin
                checkOutput($sformatf("%s d%0d rd1", step, c), 32'(obs_rd1[c]), 32'(expRead(c, rs)));
                checkOutput($sformatf("%s d%0d rd2", step, c), 32'(obs_rd2[c]), 32'(expRead(c, rt)));
            end
            checkOutput($sformatf("%s d%0d srs", step, c), 32'(obs_srs[c]), 32'(expStall(c, rs)));
            checkOutput($sformatf("%s d%0d srt", step, c), 32'(obs_srt[c]), 32'(expStall(c, rt)));
            checkOutput($sformatf("%s d%0d pend", step, c), 32'(obs_pend[c]), 32'(expPending(c)));
        end
    endtask

    // Drive one cycle of inputs after the falling edge, check the
    // combinational outputs before the rising edge, then step the model.
    task automatic applyStimulus(
        input string      step,
        input logic       i_we_a, input logic [1:0] i_wa_a, input logic [7:0] i_wd_a,
        input logic       i_we_b, input logic [1:0] i_wa_b, input logic [7:0] i_wd_b,
        input logic       i_issue, input logic [1:0] i_ird,
        input logic [1:0] i_rs, input logic [1:0] i_rt
    );
        @(negedge clk);
        we_a = i_we_a; wa_a = i_wa_a; wd_a = i_wd_a;
        we_b = i_we_b; wa_b = i_wa_b; wd_b = i_wd_b;
        issue_en = i_issue; issue_rd = i_ird;
        rs = i_rs; rt = i_rt;
        #1;
        checkAll(step, 1'b1);
        @(posedge clk);
        modelEdge();
    endtask

    task automatic idle(input string step, input logic [1:0] i_rs, input logic [1:0] i_rt);
        applyStimulus(step, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, i_rs, i_rt);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr = 1'b1;
        we_a = 1'b0; wa_a = 2'd0; wd_a = 8'h00;
        we_b = 1'b0; wa_b = 2'd0; wd_b = 8'h00;
        issue_en = 1'b0; issue_rd = 2'd0;
        rs = 2'd0; rt = 2'd3;
        modelReset();

        #3;
        checkAll("reset", 1'b1);
        checkOutput("reset pend0", 32'(obs_pend[0]), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;

        // Write and read back.
        applyStimulus("wr2", 1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd2, 2'd0);
        idle("rd2", 2'd2, 2'd2);
        checkOutput("rd2 const d0", 32'(obs_rd1[0]), 32'hA5);
        checkOutput("rd2 const d1", 32'(obs_rd1[1]), 32'hA5);

        // Forwarding vs stored-only read of register 1.
        applyStimulus("byp", 1'b1, 2'd1, 8'h3C, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd1, 2'd2);
        idle("byp after", 2'd1, 2'd1);
        checkOutput("byp after d1", 32'(obs_rd1[1]), 32'h3C);

        // Both write ports to register 3.
        applyStimulus("coll", 1'b1, 2'd3, 8'h11, 1'b1, 2'd3, 8'h22, 1'b0, 2'd0, 2'd0, 2'd3);
        idle("coll after", 2'd3, 2'd3);
        checkOutput("coll const d1", 32'(obs_rd2[1]), 32'h22);

        // Scoreboard: issue, observe stall, write back on port B.
        applyStimulus("iss1", 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd1, 2'd0);
        idle("iss1 pend", 2'd1, 2'd2);
        checkOutput("iss1 const pend", 32'(obs_pend[0]), 32'h2);
        applyStimulus("wb1", 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h5E, 1'b0, 2'd0, 2'd1, 2'd1);
        idle("wb1 after", 2'd1, 2'd1);
        applyStimulus("iss_wr1", 1'b1, 2'd1, 8'h66, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd1, 2'd0);
        idle("iss_wr1 after", 2'd1, 2'd0);
        checkOutput("iss_wr1 const d1", 32'(obs_pend[1]), 32'h2);

        // Register 0 write plus issue.
        applyStimulus("zero", 1'b1, 2'd0, 8'hFF, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd0, 2'd1);
        idle("zero after", 2'd0, 2'd0);
        checkOutput("zero const rd d1", 32'(obs_rd1[1]), 32'h00);

        // Asynchronous clear pulse between edges with state populated.
        @(negedge clk);
        we_a = 1'b0; we_b = 1'b0; issue_en = 1'b0;
        rs = 2'd2; rt = 2'd3;
        #2 clr = 1'b1;
        #1;
        modelReset();
        checkAll("clrpulse", 1'b1);
        checkOutput("clrpulse const", 32'(obs_rd1[0]), 32'h00);
        #1 clr = 1'b0;

        // Clear asserted together with a write and an issue.
        applyStimulus("pre mid", 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd3, 2'd2);
        @(negedge clk);
        we_a = 1'b1; wa_a = 2'd2; wd_a = 8'h77;
        issue_en = 1'b1; issue_rd = 2'd2;
        rs = 2'd2; rt = 2'd3;
        clr = 1'b1;
        #1;
        modelReset();
        checkAll("mid clr", 1'b0);
        @(posedge clk);
        #1;
        checkAll("mid clr edge", 1'b0);
        @(negedge clk);
        clr = 1'b0;
        we_a = 1'b0; issue_en = 1'b0;
        #1;
        checkAll("mid clr rel", 1'b1);
        checkOutput("mid clr const", 32'(obs_rd1[1]), 32'h00);
        applyStimulus("resume", 1'b1, 2'd2, 8'h5A, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0);
        idle("resume rd", 2'd2, 2'd2);
        checkOutput("resume const", 32'(obs_rd1[1]), 32'h5A);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            applyStimulus("rand",
                ($urandom_range(0, 99) < 45), 2'($urandom_range(0, 3)), 8'($urandom),
                ($urandom_range(0, 99) < 35), 2'($urandom_range(0, 3)), 8'($urandom),
                ($urandom_range(0, 99) < 40), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised multi-port register file, successor to the 4x8 single-write register file in the datapath.
- Two asynchronous read ports and two synchronous write ports.
- Same-cycle write-to-read forwarding.
- Optional hardwired-zero register 0.
- Per-register pending scoreboard, so the control unit can stall on read-after-write hazards from multi-cycle producers.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 2, register address width; NREG = 2**ADDR_W registers.
- ZERO_REG, 0, when 1, register 0 always reads 0, ignores writes and never goes pending.
- BYPASS, 1, when 1, read ports forward same-cycle write data; when 0, reads return stored contents only.

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  reset, asynchronous, active-high.
- rs  input  ADDR_W  read address, port 1.
- rt  input  ADDR_W  read address, port 2.
- rd_data1  output  DATA_W  read data, port 1.
- rd_data2  output  DATA_W  read data, port 2.
- we_a  input  1  write enable, port A.
- wa_a  input  ADDR_W  write address, port A.
- wd_a  input  DATA_W  write data, port A.
- we_b  input  1  write enable, port B (higher priority).
- wa_b  input  ADDR_W  write address, port B.
- wd_b  input  DATA_W  write data, port B.
- issue_en  input  1  mark destination register pending.
- issue_rd  input  ADDR_W  destination register being issued.
- stall_rs  output  1  rs is pending and not being resolved this cycle.
- stall_rt  output  1  rt is pending and not being resolved this cycle.
- pending  output  NREG  scoreboard bit vector; bit i means register i is pending.

Behaviour:
- Reset (clr=1, asynchronous): all registers = 0 and pending = 0, so stall_rs = stall_rt = 0.
  - rd_data reflects the zeroed contents immediately; no clock is required.
  - clr mid-operation discards any write or issue in that cycle.
- Write (rising clk, clr=0):
  - If we_a, reg[wa_a] <= wd_a. If we_b, reg[wb] <= wd_b.
  - When both ports target the same address, port B's data is stored.
  - When ZERO_REG=1, writes to address 0 are dropped.
- Read (combinational, zero latency):
  - BYPASS=1 priority: port B match (we_b && wa_b==addr), then port A match, then stored reg[addr].
  - BYPASS=0: stored reg[addr] only.
  - ZERO_REG=1 with addr 0: output is 0 regardless of bypass.
- Scoreboard (rising clk):
  - A write on either port to register i clears pending[i].
  - issue_en && issue_rd==i sets pending[i].
  - Issue and write to the same register in the same cycle: set wins, so pending stays 1 (the new producer is outstanding).
  - ZERO_REG=1: pending[0] stays 0.
- Stall (combinational):
  - stall_rs = pending[rs] && !(BYPASS && a write to rs is occurring this cycle). stall_rt is defined the same way.
  - With BYPASS=0, stall holds through the writeback cycle and drops the cycle after.
  - Issuing a register does not affect stall in the same cycle; it affects it from the next cycle.
- Widths: addresses are unsigned and never out of range, since NREG = 2**ADDR_W exactly. No arithmetic is performed.
- No X propagation: all storage is defined from reset; stall and pending outputs never depend on write data.

Test Plan:
- Reset/default:
  - Pulse clr between edges -> all rd_data = 0x00, pending = 4'b0000 immediately.
  - Write reg2 = 0xA5 via port A, then read rs=2 -> 0xA5 on the next cycle.
- Bypass:
  - With BYPASS=1, rs=1, we_a=1, wa_a=1, wd_a=0x3C in the same cycle -> rd_data1 = 0x3C before the edge.
  - With BYPASS=0 -> old value before the edge, 0x3C after the edge.
- Write collision:
  - we_a=we_b=1, wa_a=wa_b=3, wd_a=0x11, wd_b=0x22 -> rd_data2(rt=3) = 0x22 both forwarded and stored.
- Scoreboard:
  - Issue rd=1 -> pending = 4'b0010 next cycle and stall_rs=1 for rs=1.
  - Writeback on port B to 1 -> stall_rs=0 in that cycle (BYPASS=1) and pending = 0 after the edge.
  - Issue and write to 1 in the same cycle -> pending[1] remains 1.
- ZERO_REG=1:
  - Write 0xFF to reg0 and issue rd=0 -> rd_data1(rs=0) = 0x00 and pending[0] = 0 throughout.
- Async reset mid-op:
  - Assert clr together with we_a, issue_en -> registers and pending stay 0.
  - Deassert clr -> normal writes resume on the next edge.
